hack_cpu_hs: RTL and testbench

//  Next-generation Hack CPU core. It adds a ready/valid handshake on the instruction,

---
 rtl/hack_cpu_hs.sv | 164 ++++++++++++++++
 tb/tb_hack_cpu_hs.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hack_cpu_hs.sv
// Hack CPU core with ready/valid handshakes on instruction fetch, data read and data write,
// plus an optional detector for jump-to-self halt loops.
module hack_cpu_hs #(
    parameter int unsigned DATA_WIDTH    = 16,
    parameter int unsigned ADDRESS_WIDTH = 16,
    parameter int unsigned INST_WIDTH    = DATA_WIDTH,
    parameter bit          HALT_DETECT   = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [INST_WIDTH-1:0]    instruction_in,
    input  logic                     instruction_valid,
    input  logic [DATA_WIDTH-1:0]    data_in,
    input  logic                     data_valid,
    input  logic                     write_ready,
    output logic [ADDRESS_WIDTH-1:0] pc_out,
    output logic [ADDRESS_WIDTH-1:0] address_out,
    output logic [DATA_WIDTH-1:0]    data_out,
    output logic                     read_out,
    output logic                     write_out,
    output logic                     halted
);

    localparam int unsigned DW = DATA_WIDTH;
    localparam int unsigned AW = ADDRESS_WIDTH;
    localparam int unsigned IW = INST_WIDTH;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_WRITE = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t          state_q, state_n;
    logic [AW-1:0]   pc_q, pc_n;
    logic [DW-1:0]   a_q, a_n;
    logic [DW-1:0]   d_q, d_n;
    logic [IW-1:0]   ir_q, ir_n;
    logic [AW-1:0]   wr_addr_q, wr_addr_n;
    logic [DW-1:0]   wr_data_q, wr_data_n;
    logic            halted_q, halted_n;
    logic [AW-1:0]   addr_q, addr_n;
    logic            read_q, read_n;
    logic            write_q, write_n;

    logic [DW-1:0]   x_z, x_n, y_src, y_z, y_n, f_out, alu_out;
    logic            zr, ng, jump_take, halt_hit;
    logic [AW-1:0]   target, pc_inc;

    // Hack ALU: x = D, y = A or M selected by the a-bit
    always_comb begin
        x_z     = ir_q[11] ? DW'(0) : d_q;
        x_n     = ir_q[10] ? ~x_z : x_z;
        y_src   = ir_q[12] ? data_in : a_q;
        y_z     = ir_q[9] ? DW'(0) : y_src;
        y_n     = ir_q[8] ? ~y_z : y_z;
        f_out   = ir_q[7] ? (x_n + y_n) : (x_n & y_n);
        alu_out = ir_q[6] ? ~f_out : f_out;
    end

    // Jump target and memory address come from A before this instruction writes it
    assign ng        = alu_out[DW-1];
    assign zr        = (alu_out == DW'(0));
    assign jump_take = (ir_q[2] & ng) | (ir_q[1] & zr) | (ir_q[0] & ~ng & ~zr);
    assign target    = a_q[AW-1:0];
    assign pc_inc    = pc_q + AW'(1);
    assign halt_hit  = HALT_DETECT && jump_take && (target == pc_q);

    always_comb begin
        state_n   = state_q;
        pc_n      = pc_q;
        a_n       = a_q;
        d_n       = d_q;
        ir_n      = ir_q;
        wr_addr_n = wr_addr_q;
        wr_data_n = wr_data_q;
        halted_n  = halted_q;
        read_n    = 1'b0;
        write_n   = 1'b0;
        addr_n    = addr_q;

        case (state_q)
            S_FETCH: begin
                if (instruction_valid) begin
                    ir_n    = instruction_in;
                    state_n = S_EXEC;
                end
            end
            S_EXEC: begin
                if (!ir_q[IW-1]) begin
                    a_n     = DW'(ir_q[IW-2:0]);
                    pc_n    = pc_inc;
                    state_n = S_FETCH;
                end else if (!ir_q[12] || data_valid) begin
                    if (ir_q[5]) a_n = alu_out;
                    if (ir_q[4]) d_n = alu_out;
                    if (ir_q[3]) begin
                        wr_addr_n = target;
                        wr_data_n = alu_out;
                        pc_n      = jump_take ? target : pc_inc;
                        state_n   = S_WRITE;
                    end else if (halt_hit) begin
                        halted_n = 1'b1;
                        state_n  = S_HALT;
                    end else begin
                        pc_n    = jump_take ? target : pc_inc;
                        state_n = S_FETCH;
                    end
                end
            end
            S_WRITE: begin
                if (write_ready) state_n = S_FETCH;
            end
            S_HALT: begin
                state_n = S_HALT;
            end
            default: begin
                state_n = S_FETCH;
            end
        endcase

        // Bus outputs are registered copies of what the next state presents
        read_n  = (state_n == S_EXEC) && ir_n[IW-1] && ir_n[12];
        write_n = (state_n == S_WRITE);
        addr_n  = write_n ? wr_addr_n : a_n[AW-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            pc_q      <= '0;
            a_q       <= '0;
            d_q       <= '0;
            ir_q      <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            halted_q  <= 1'b0;
            addr_q    <= '0;
            read_q    <= 1'b0;
            write_q   <= 1'b0;
        end else begin
            state_q   <= state_n;
            pc_q      <= pc_n;
            a_q       <= a_n;
            d_q       <= d_n;
            ir_q      <= ir_n;
            wr_addr_q <= wr_addr_n;
            wr_data_q <= wr_data_n;
            halted_q  <= halted_n;
            addr_q    <= addr_n;
            read_q    <= read_n;
            write_q   <= write_n;
        end
    end

    assign pc_out      = pc_q;
    assign address_out = addr_q;
    assign data_out    = wr_data_q;
    assign read_out    = read_q;
    assign write_out   = write_q;
    assign halted      = halted_q;

endmodule

// File: tb/tb_hack_cpu_hs.sv
// Bench for hack_cpu_hs: directed programs plus random programs checked against an ISA-level model,
// with ROM/RAM responders that insert fixed or random wait states.
module tb_hack_cpu_hs;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] instruction_in, data_in;
    logic        instruction_valid, data_valid, write_ready;
    logic [15:0] pc_out, address_out, data_out;
    logic        read_out, write_out, halted;

    logic [15:0] ins2, pc2, addr2, dout2;
    logic        rd2, wr2, halted2;

    logic [15:0] rom  [0:65535];
    logic [15:0] ram  [0:65535];
    logic [15:0] mram [0:65535];

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
        logic [15:0] pc;
        int          len;
        bit          stable;
    } wr_t;

    typedef struct {
        logic [15:0] addr;
        int          len;
    } rd_t;

    wr_t         wr_log [$];
    rd_t         rd_log [$];
    logic [31:0] exp_wr [$];

    int n_tests, n_fail;
    bit rand_mode;
    int rd_wait, wr_wait, rd_wait_fix, wr_wait_fix, rcnt, wcnt;
    logic [15:0] w0_a, w0_d, w0_p;
    bit wstab;

    always #5 clk = ~clk;

    assign instruction_in = rom[pc_out];
    assign ins2           = rom[pc2];

    hack_cpu_hs #(.DATA_WIDTH(16), .ADDRESS_WIDTH(16), .INST_WIDTH(16), .HALT_DETECT(1'b1)) u_dut (
        .clk(clk), .rst(rst),
        .instruction_in(instruction_in), .instruction_valid(instruction_valid),
        .data_in(data_in), .data_valid(data_valid), .write_ready(write_ready),
        .pc_out(pc_out), .address_out(address_out), .data_out(data_out),
        .read_out(read_out), .write_out(write_out), .halted(halted)
    );

    hack_cpu_hs #(.DATA_WIDTH(16), .ADDRESS_WIDTH(16), .INST_WIDTH(16), .HALT_DETECT(1'b0)) u_dut_nh (
        .clk(clk), .rst(rst),
        .instruction_in(ins2), .instruction_valid(1'b1),
        .data_in(16'h0000), .data_valid(1'b1), .write_ready(1'b1),
        .pc_out(pc2), .address_out(addr2), .data_out(dout2),
        .read_out(rd2), .write_out(wr2), .halted(halted2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Memory responders and bus monitor, all on the falling edge
    always @(negedge clk) begin
        instruction_valid = rand_mode ? ($urandom_range(0, 9) < 7) : 1'b1;
        if (read_out) begin
            data_valid = (rcnt >= rd_wait);
            rcnt++;
        end else begin
            data_valid = 1'b0;
            rcnt       = 0;
            rd_wait    = rand_mode ? int'($urandom_range(0, 3)) : rd_wait_fix;
        end
        data_in = data_valid ? ram[address_out] : 16'($urandom);
        if (read_out && data_valid) rd_log.push_back('{address_out, rcnt});
        if (write_out) begin
            if (wcnt == 0) begin
                w0_a  = address_out;
                w0_d  = data_out;
                w0_p  = pc_out;
                wstab = 1'b1;
            end else if (address_out !== w0_a || data_out !== w0_d || pc_out !== w0_p) begin
                wstab = 1'b0;
            end
            write_ready = (wcnt >= wr_wait);
            wcnt++;
            if (write_ready) begin
                ram[address_out] = data_out;
                wr_log.push_back('{address_out, data_out, pc_out, wcnt, wstab});
            end
        end else begin
            write_ready = 1'b0;
            wcnt        = 0;
            wr_wait     = rand_mode ? int'($urandom_range(0, 3)) : wr_wait_fix;
        end
        if (read_out && write_out) check("rw_excl", 32'd1, 32'd0);
    end

    function automatic wr_t wr_at(int i);
        wr_t e;
        e = '{16'hxxxx, 16'hxxxx, 16'hxxxx, -1, 1'b0};
        if (i < wr_log.size()) e = wr_log[i];
        return e;
    endfunction

    function automatic rd_t rd_at(int i);
        rd_t e;
        e = '{16'hxxxx, -1};
        if (i < rd_log.size()) e = rd_log[i];
        return e;
    endfunction

    function automatic logic [15:0] alu(logic [5:0] c, logic [15:0] x, logic [15:0] y);
        logic [15:0] xx, yy, r;
        xx = c[5] ? 16'h0000 : x;
        if (c[4]) xx = ~xx;
        yy = c[3] ? 16'h0000 : y;
        if (c[2]) yy = ~yy;
        r = c[1] ? 16'(xx + yy) : (xx & yy);
        if (c[0]) r = ~r;
        return r;
    endfunction

    function automatic logic [5:0] comp_code(int k);
        case (k)
            0: return 6'b101010;  1: return 6'b111111;  2: return 6'b111010;
            3: return 6'b001100;  4: return 6'b110000;  5: return 6'b001101;
            6: return 6'b110001;  7: return 6'b001111;  8: return 6'b110011;
            9: return 6'b011111; 10: return 6'b110111; 11: return 6'b001110;
           12: return 6'b110010; 13: return 6'b000010; 14: return 6'b010011;
           15: return 6'b000111; 16: return 6'b000000;
            default: return 6'b010101;
        endcase
    endfunction

    // Instruction-level interpreter of the Hack ISA with the jump-to-self halt rule
    task automatic model_run(output bit hm, output logic [15:0] pm);
        logic [15:0] pc, a, d, ir, y, o, olda;
        bit tk;
        exp_wr.delete();
        pc = 0; a = 0; d = 0; hm = 1'b0;
        for (int s = 0; s < 400 && !hm; s++) begin
            ir = rom[pc];
            if (!ir[15]) begin
                a  = ir;
                pc = pc + 16'd1;
            end else begin
                y    = ir[12] ? mram[a] : a;
                o    = alu(ir[11:6], d, y);
                tk   = (ir[2] && $signed(o) < 0) || (ir[1] && o == 0) || (ir[0] && $signed(o) > 0);
                olda = a;
                if (ir[5]) a = o;
                if (ir[4]) d = o;
                if (ir[3]) begin
                    mram[olda] = o;
                    exp_wr.push_back({olda, o});
                end
                if (tk && olda == pc && !ir[3]) hm = 1'b1;
                else pc = tk ? olda : pc + 16'd1;
            end
        end
        pm = pc;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 65536; i++) begin
            rom[i] = 16'h0; ram[i] = 16'h0; mram[i] = 16'h0;
        end
    endtask

    task automatic gen_prog();
        for (int i = 0; i < 22; i++) begin
            if ($urandom_range(0, 9) < 4)
                rom[i] = 16'($urandom_range(0, 23));
            else
                rom[i] = {3'b111, 1'($urandom_range(0, 1)), comp_code(int'($urandom_range(0, 17))),
                          3'($urandom_range(0, 7)),
                          ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000};
        end
        rom[22] = 16'd23;
        rom[23] = 16'hEA87;
        for (int i = 0; i < 32; i++) begin
            ram[i]  = 16'($urandom);
            mram[i] = ram[i];
        end
    endtask

    task automatic rst_on();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic rst_off();
        rst = 1'b0;
        wr_log.delete();
        rd_log.delete();
    endtask

    task automatic run_until_halt(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            ok = halted;
        end
    endtask

    task automatic load_sum_prog();
        rom[0] = 16'd2;   rom[1] = 16'hEC10;   // @2; D=A
        rom[2] = 16'd3;   rom[3] = 16'hE090;   // @3; D=D+A
        rom[4] = 16'd0;   rom[5] = 16'hE308;   // @0; M=D
        rom[6] = 16'd7;   rom[7] = 16'hEA87;   // @7; 0;JMP
    endtask

    initial begin
        bit ok, hm, seen;
        logic [15:0] pm;
        int tries;
        rst = 1'b1; rand_mode = 1'b0;
        instruction_valid = 1'b1; data_valid = 1'b0; write_ready = 1'b0; data_in = 16'h0;
        n_tests = 0; n_fail = 0; rd_wait = 0; wr_wait = 0; rd_wait_fix = 0; wr_wait_fix = 0;
        rcnt = 0; wcnt = 0; wstab = 1'b1; w0_a = 0; w0_d = 0; w0_p = 0;

        // Sum program with zero wait states
        rst_on();
        check("rst_pc", pc_out, 0);
        check("rst_addr", address_out, 0);
        check("rst_dout", data_out, 0);
        check("rst_rd", read_out, 0);
        check("rst_wr", write_out, 0);
        check("rst_halt", halted, 0);
        clear_mem(); load_sum_prog();
        rst_off();
        run_until_halt(300, ok);
        check("t1_halt", ok, 1);
        check("t1_nwr", wr_log.size(), 1);
        check("t1_wr", {wr_at(0).addr, wr_at(0).data}, {16'd0, 16'd5});
        check("t1_wr_pc", wr_at(0).pc, 6);
        check("t1_wr_len", wr_at(0).len, 1);
        check("t1_pc", pc_out, 7);

        // Same program, write held off for three cycles
        rst_on();
        clear_mem(); load_sum_prog(); wr_wait_fix = 3;
        rst_off();
        run_until_halt(300, ok);
        check("t2_wr", {wr_at(0).addr, wr_at(0).data}, {16'd0, 16'd5});
        check("t2_wr_len", wr_at(0).len, 4);
        check("t2_wr_stable", wr_at(0).stable, 1);
        check("t2_wr_pc", wr_at(0).pc, 6);

        // M read with two cycles of read wait
        rst_on();
        clear_mem(); wr_wait_fix = 0; rd_wait_fix = 2;
        rom[0] = 16'd7;  rom[1] = 16'hFC10;        // @7; D=M
        rom[2] = 16'd20; rom[3] = 16'hE308;        // @20; M=D
        rom[4] = 16'd5;  rom[5] = 16'hEA87;        // @5; 0;JMP
        ram[7] = 16'h1234;
        rst_off();
        run_until_halt(300, ok);
        check("t3_nrd", rd_log.size(), 1);
        check("t3_rd_addr", rd_at(0).addr, 7);
        check("t3_rd_len", rd_at(0).len, 3);
        check("t3_wr", {wr_at(0).addr, wr_at(0).data}, {16'd20, 16'h1234});
        check("t3_pc", pc_out, 5);

        // Conditional not-taken, unconditional jump, and AM=D+1;JMP using the old A
        rst_on();
        clear_mem(); rd_wait_fix = 0;
        rom[0] = 16'hEE90;                         // D=-1
        rom[1] = 16'd10; rom[2] = 16'hE301;        // @10; D;JGT
        rom[3] = 16'd4;  rom[4] = 16'hEC10;        // @4; D=A
        rom[5] = 16'd10; rom[6] = 16'hEA87;        // @10; 0;JMP
        rom[10] = 16'hE7EF;                        // AM=D+1;JMP
        rst_off();
        repeat (60) @(negedge clk);
        check("t4_wr0", {wr_at(0).addr, wr_at(0).data}, {16'd10, 16'd5});
        check("t4_wr0_pc", wr_at(0).pc, 10);
        check("t4_wr1", {wr_at(1).addr, wr_at(1).data}, {16'd5, 16'd5});
        check("t4_wr1_pc", wr_at(1).pc, 5);
        check("t4_nohalt", halted, 0);

        // Jump-to-self halt, and the same loop on the instance without detection
        rst_on();
        clear_mem();
        rom[0] = 16'd5; rom[1] = 16'hEC10; rom[2] = 16'd3; rom[3] = 16'hEA87;
        rst_off();
        run_until_halt(100, ok);
        check("t5_halt", ok, 1);
        check("t5_pc", pc_out, 3);
        repeat (20) @(negedge clk);
        check("t5_pc_hold", pc_out, 3);
        check("t5_halt_hold", halted, 1);
        check("t5_nh_halt", halted2, 0);
        check("t5_nh_pc", pc2, 3);

        // Reset while stuck in a write, then again while halted
        rst_on();
        clear_mem(); wr_wait_fix = 100;
        rom[0] = 16'd3; rom[1] = 16'hEC10; rom[2] = 16'd8; rom[3] = 16'hE308;
        rst_off();
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = write_out;
        end
        check("t6_wr_seen", seen, 1);
        repeat (2) @(negedge clk);
        rst_on();
        check("t6_wr_off", write_out, 0);
        check("t6_halt", halted, 0);
        check("t6_pc", pc_out, 0);
        check("t6_addr", address_out, 0);
        check("t6_dout", data_out, 0);
        rom[0] = 16'd8; rom[1] = 16'hE308; rom[2] = 16'd3; rom[3] = 16'hEA87;
        wr_wait_fix = 0;
        rst_off();
        run_until_halt(200, ok);
        check("t6_rehalt", ok, 1);
        check("t6_nwr", wr_log.size(), 1);
        check("t6_d_zero", {wr_at(0).addr, wr_at(0).data}, {16'd8, 16'd0});
        rst_on();
        check("t6h_halt", halted, 0);
        check("t6h_pc", pc_out, 0);
        check("t6h_addr", address_out, 0);

        // Random programs with random wait states against the model
        for (int p = 0; p < 8; p++) begin
            rst_on();
            rand_mode = 1'b1;
            tries = 0;
            do begin
                clear_mem();
                gen_prog();
                model_run(hm, pm);
                tries++;
            end while (!hm && tries < 50);
            rst_off();
            run_until_halt(20000, ok);
            check("rand_halt", ok, 1);
            check("rand_pc", pc_out, pm);
            check("rand_nwr", wr_log.size(), exp_wr.size());
            for (int i = 0; i < exp_wr.size(); i++)
                check("rand_wr", {wr_at(i).addr, wr_at(i).data}, exp_wr[i]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
